// File: rtl/count_log_pkg.sv
// Shared widths, state encodings and helpers for the counter sample log reader.
package count_log_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;

  typedef logic [DW-1:0] sample_t;

  // Counter wrap value; marks the end of a run on the read port
  localparam sample_t ALL_ONES = '1;

  typedef enum logic {
    CHK_UNSYNC = 1'b0,
    CHK_LOCKED = 1'b1
  } chk_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Expected successor of a count sample (wraps mod 2^DW)
  function automatic sample_t next_count(input sample_t v);
    return v + DW'(1);
  endfunction

endpackage

// File: rtl/count_log_reader_if.sv
// Write-strobe and valid/ready read signals between the logger, the log and the host side.
interface count_log_reader_if;
  import count_log_pkg::*;

  logic    wr_en;
  sample_t wr_data;
  logic    rd_ready;
  logic    rd_valid;
  sample_t rd_data;
  logic    rd_last;

  modport master (
    output wr_en,
    output wr_data,
    output rd_ready,
    input  rd_valid,
    input  rd_data,
    input  rd_last
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_ready,
    output rd_valid,
    output rd_data,
    output rd_last
  );

endinterface

// File: rtl/count_log_mem.sv
// DEPTH x DW sample store: one write port, one synchronous read port whose register
// doubles as the reader's output word.
module count_log_mem #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DW-1:0]            o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register only loads on a pop, so the word holds steady while the host stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/count_log_reader.sv
// Reader end of the counter sample log: buffers write-strobed samples, drains them over
// valid/ready and checks the drained stream counts up by one. Optional COUNT_LOG_STATS_EN
// adds handshake and sequence-error counters.
module count_log_reader
  import count_log_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  count_log_reader_if.slave   bus,
  input  logic                clr_flags,
  output logic [LW-1:0]       level,
  output logic                overrun,
  output logic                seq_err
`ifdef COUNT_LOG_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [7:0]          err_count
`endif
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  out_state_e    r_out_state;
  chk_state_e    r_chk_state;
  sample_t       r_prev;
  logic          r_overrun;
  logic          r_seq_err;

  logic          w_pop;
  logic          w_push;
  logic          w_hs;
  logic          w_mismatch;
  sample_t       w_rd_data;

  // Pop whenever the output word is free or being consumed; a full log still
  // takes a write in the same cycle it frees a slot.
  assign w_hs       = (r_out_state == OUT_VALID) && bus.rd_ready;
  assign w_pop      = (r_level != '0) && ((r_out_state == OUT_EMPTY) || bus.rd_ready);
  assign w_push     = bus.wr_en && ((r_level != LW'(DEPTH)) || w_pop);
  assign w_mismatch = w_hs && (r_chk_state == CHK_LOCKED) && (w_rd_data != next_count(r_prev));

  count_log_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Pointers wrap freely at DEPTH; level tracks memory occupancy only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // Output word state: valid only drops after a handshake with nothing left to reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_state <= OUT_EMPTY;
    end else if (r_out_state == OUT_EMPTY) begin
      if (r_level != '0) begin
        r_out_state <= OUT_VALID;
      end
    end else begin
      if (bus.rd_ready && (r_level == '0)) begin
        r_out_state <= OUT_EMPTY;
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      if (bus.wr_en && !w_push) begin
        r_overrun <= 1'b1;
      end else if (clr_flags) begin
        r_overrun <= 1'b0;
      end
      if (w_mismatch) begin
        r_seq_err <= 1'b1;
      end else if (clr_flags) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  // Sequence checker: first delivered sample after reset/clear only seeds the reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_state <= CHK_UNSYNC;
      r_prev      <= '0;
    end else if (clr_flags) begin
      r_chk_state <= CHK_UNSYNC;
    end else if (w_hs) begin
      r_chk_state <= CHK_LOCKED;
      r_prev      <= w_rd_data;
    end
  end

`ifdef COUNT_LOG_STATS_EN
  logic [15:0] r_rd_count;
  logic [7:0]  r_err_count;

  // Saturating event counters, zeroed by clr_flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else if (clr_flags) begin
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (w_hs && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (w_mismatch && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign rd_count  = r_rd_count;
  assign err_count = r_err_count;
`endif

  assign bus.rd_valid = (r_out_state == OUT_VALID);
  assign bus.rd_data  = w_rd_data;
  assign bus.rd_last  = (w_rd_data == ALL_ONES);
  assign level        = r_level;
  assign overrun      = r_overrun;
  assign seq_err      = r_seq_err;

endmodule
